// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: merges the ALU result stream with a queued load-result stream
// and keeps a per-register pending-write scoreboard.
module writeback_arbiter #(
    parameter int unsigned LD_FIFO_DEPTH = 4
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core,
    input  logic        Alu_Valid,
    input  logic [4:0]  Alu_Rd,
    input  logic [31:0] Alu_Data,
    output logic        Alu_Ready,
    input  logic        Ld_Valid,
    input  logic [4:0]  Ld_Rd,
    input  logic [31:0] Ld_Data,
    output logic        Ld_Ready,
    input  logic        Issue_Valid,
    input  logic [4:0]  Issue_Rd,
    output logic [31:0] Busy_Vec,
    output logic        Wr_En,
    output logic [4:0]  Write_Addr_Port_1,
    output logic [31:0] Write_Data_Port_1
);

    localparam int unsigned PTR_W  = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        GRANT_LOAD = 1'b0,
        GRANT_ALU  = 1'b1
    } grant_t;

    wb_entry_t        ld_mem [LD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] ld_count;
    grant_t           last_grant;

    logic             fifo_empty;
    logic             push;
    logic             alu_grant;
    logic             ld_grant;
    logic             contended;
    wb_entry_t        sel;
    logic [NREG-1:0]  set_mask;
    logic [NREG-1:0]  clr_mask;
    logic [NREG-1:0]  busy_next;

    assign fifo_empty = (ld_count == '0);
    assign Ld_Ready   = (ld_count < CNT_W'(LD_FIFO_DEPTH));
    assign push       = Ld_Valid && Ld_Ready;
    assign contended  = Alu_Valid && !fifo_empty;
    assign Alu_Ready  = alu_grant;

    // Round-robin grant; a freshly pushed load is never visible in its push cycle.
    always_comb begin
        alu_grant = 1'b0;
        ld_grant  = 1'b0;
        if (!Rst_Core) begin
            if (Alu_Valid && (fifo_empty || last_grant == GRANT_LOAD)) begin
                alu_grant = 1'b1;
            end else if (!fifo_empty) begin
                ld_grant = 1'b1;
            end
        end
    end

    always_comb begin
        sel = alu_grant ? wb_entry_t'{rd: Alu_Rd, data: Alu_Data} : ld_mem[rd_ptr];
    end

    // Set wins over clear when the same register is issued and retired on one edge.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (Issue_Valid && Issue_Rd != '0) begin
            set_mask[Issue_Rd] = 1'b1;
        end
        if ((alu_grant || ld_grant) && sel.rd != '0) begin
            clr_mask[sel.rd] = 1'b1;
        end
        busy_next    = (Busy_Vec & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    // Storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge Clk_Core) begin
        if (push) begin
            ld_mem[wr_ptr] <= wb_entry_t'{rd: Ld_Rd, data: Ld_Data};
        end
    end

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ld_count   <= '0;
            last_grant <= GRANT_LOAD;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (ld_grant) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !ld_grant) begin
                ld_count <= ld_count + CNT_W'(1);
            end else if (!push && ld_grant) begin
                ld_count <= ld_count - CNT_W'(1);
            end
            if (contended) begin
                last_grant <= alu_grant ? GRANT_ALU : GRANT_LOAD;
            end
        end
    end

    // Writeback port: one-cycle pulse per result; x0 results are consumed silently.
    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            Wr_En             <= 1'b0;
            Write_Addr_Port_1 <= '0;
            Write_Data_Port_1 <= '0;
            Busy_Vec          <= '0;
        end else begin
            Busy_Vec <= busy_next;
            if ((alu_grant || ld_grant) && sel.rd != '0) begin
                Wr_En             <= 1'b1;
                Write_Addr_Port_1 <= sel.rd;
                Write_Data_Port_1 <= sel.data;
            end else begin
                Wr_En <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, ALU path, contention, backpressure, scoreboard,
// x0 discard and mid-stream reset, with an independent load-FIFO occupancy monitor.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        Clk_Core = 1'b0;
    logic        Rst_Core = 1'b1;
    logic        Alu_Valid = 1'b0;
    logic [4:0]  Alu_Rd = '0;
    logic [31:0] Alu_Data = '0;
    logic        Alu_Ready;
    logic        Ld_Valid = 1'b0;
    logic [4:0]  Ld_Rd = '0;
    logic [31:0] Ld_Data = '0;
    logic        Ld_Ready;
    logic        Issue_Valid = 1'b0;
    logic [4:0]  Issue_Rd = '0;
    logic [31:0] Busy_Vec;
    logic        Wr_En;
    logic [4:0]  Write_Addr_Port_1;
    logic [31:0] Write_Data_Port_1;

    int checks   = 0;
    int failures = 0;
    int mon_fail = 0;

    writeback_arbiter #(.LD_FIFO_DEPTH(DEPTH)) dut (
        .Clk_Core          (Clk_Core),
        .Rst_Core          (Rst_Core),
        .Alu_Valid         (Alu_Valid),
        .Alu_Rd            (Alu_Rd),
        .Alu_Data          (Alu_Data),
        .Alu_Ready         (Alu_Ready),
        .Ld_Valid          (Ld_Valid),
        .Ld_Rd             (Ld_Rd),
        .Ld_Data           (Ld_Data),
        .Ld_Ready          (Ld_Ready),
        .Issue_Valid       (Issue_Valid),
        .Issue_Rd          (Issue_Rd),
        .Busy_Vec          (Busy_Vec),
        .Wr_En             (Wr_En),
        .Write_Addr_Port_1 (Write_Addr_Port_1),
        .Write_Data_Port_1 (Write_Data_Port_1)
    );

    always #5 Clk_Core = ~Clk_Core;

    // Occupancy model: a load pops whenever the FIFO holds data and the ALU is not accepted.
    int   occ = 0;
    logic cap_push = 1'b0;
    logic cap_pop  = 1'b0;

    always @(negedge Clk_Core) begin
        if (Rst_Core) begin
            cap_push <= 1'b0;
            cap_pop  <= 1'b0;
        end else begin
            cap_push <= Ld_Valid && Ld_Ready;
            cap_pop  <= (occ > 0) && !(Alu_Valid && Alu_Ready);
            if (Ld_Ready !== (occ < DEPTH)) begin
                mon_fail <= mon_fail + 1;
                $display("FAIL mon_ld_ready t=%0t got=%b exp=%b occ=%0d", $time, Ld_Ready, (occ < DEPTH), occ);
            end
            if (Ld_Valid && Ld_Ready && occ >= DEPTH) begin
                mon_fail <= mon_fail + 1;
                $display("FAIL mon_push_when_full t=%0t occ=%0d", $time, occ);
            end
            if (Alu_Valid && !Alu_Ready && occ == 0) begin
                mon_fail <= mon_fail + 1;
                $display("FAIL mon_pop_when_empty t=%0t", $time);
            end
        end
    end

    always @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) occ <= 0;
        else          occ <= occ + int'(cap_push) - int'(cap_pop);
    end

    task automatic tick();
        @(posedge Clk_Core);
        #1;
    endtask

    task automatic idle_inputs();
        Alu_Valid   = 1'b0;
        Ld_Valid    = 1'b0;
        Issue_Valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Rst_Core = 1'b1;
        tick();
        Rst_Core = 1'b0;
    endtask

    task automatic test_reset();
        Rst_Core  = 1'b1;
        Alu_Valid = 1'b1;
        Alu_Rd    = 5'd5;
        Alu_Data  = 32'h1234_5678;
        tick();
        checks++; if (Wr_En !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", Wr_En); end
        checks++; if (Write_Addr_Port_1 !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", Write_Addr_Port_1); end
        checks++; if (Write_Data_Port_1 !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", Write_Data_Port_1); end
        checks++; if (Busy_Vec !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", Busy_Vec); end
        checks++; if (Ld_Ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got=%b exp=1", Ld_Ready); end
        checks++; if (Alu_Ready !== 1'b0) begin failures++; $display("FAIL reset_alu_ready got=%b exp=0", Alu_Ready); end
        Alu_Valid = 1'b0;
        Rst_Core  = 1'b0;
    endtask

    task automatic test_alu_only();
        Alu_Valid = 1'b1;
        Alu_Rd    = 5'd5;
        Alu_Data  = 32'hDEAD_BEEF;
        #1;
        checks++; if (Alu_Ready !== 1'b1) begin failures++; $display("FAIL alu_ready got=%b exp=1", Alu_Ready); end
        tick();
        Alu_Valid = 1'b0;
        checks++; if (Wr_En !== 1'b1) begin failures++; $display("FAIL alu_wr_en got=%b exp=1", Wr_En); end
        checks++; if (Write_Addr_Port_1 !== 5'd5) begin failures++; $display("FAIL alu_addr got=%0d exp=5", Write_Addr_Port_1); end
        checks++; if (Write_Data_Port_1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alu_data got=%h exp=deadbeef", Write_Data_Port_1); end
        tick();
        checks++; if (Wr_En !== 1'b0) begin failures++; $display("FAIL alu_pulse got=%b exp=0", Wr_En); end
        checks++; if (Write_Addr_Port_1 !== 5'd5 || Write_Data_Port_1 !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL alu_hold got=%0d/%h exp=5/deadbeef", Write_Addr_Port_1, Write_Data_Port_1);
        end
    endtask

    task automatic test_contention();
        do_reset();
        Ld_Valid = 1'b1; Ld_Rd = 5'd7; Ld_Data = 32'h11;
        tick();
        Ld_Rd = 5'd8; Ld_Data = 32'h22;
        Alu_Valid = 1'b1; Alu_Rd = 5'd9; Alu_Data = 32'h33;
        #1;
        checks++; if (Alu_Ready !== 1'b1) begin failures++; $display("FAIL cont_alu_first got=%b exp=1", Alu_Ready); end
        tick();
        Ld_Valid = 1'b0; Alu_Valid = 1'b0;
        checks++; if (Wr_En !== 1'b1 || Write_Addr_Port_1 !== 5'd9 || Write_Data_Port_1 !== 32'h33) begin
            failures++; $display("FAIL cont_w0 got=%b/%0d/%h exp=1/9/33", Wr_En, Write_Addr_Port_1, Write_Data_Port_1);
        end
        tick();
        checks++; if (Wr_En !== 1'b1 || Write_Addr_Port_1 !== 5'd7 || Write_Data_Port_1 !== 32'h11) begin
            failures++; $display("FAIL cont_w1 got=%b/%0d/%h exp=1/7/11", Wr_En, Write_Addr_Port_1, Write_Data_Port_1);
        end
        tick();
        checks++; if (Wr_En !== 1'b1 || Write_Addr_Port_1 !== 5'd8 || Write_Data_Port_1 !== 32'h22) begin
            failures++; $display("FAIL cont_w2 got=%b/%0d/%h exp=1/8/22", Wr_En, Write_Addr_Port_1, Write_Data_Port_1);
        end
        tick();
        checks++; if (Wr_En !== 1'b0) begin failures++; $display("FAIL cont_idle got=%b exp=0", Wr_En); end
    endtask

    task automatic test_backpressure();
        int   issued  = 0;
        int   written = 0;
        int   alu_w   = 0;
        bit   saw_full = 1'b0;
        logic accept;
        do_reset();
        Alu_Valid = 1'b1; Alu_Rd = 5'd1; Alu_Data = 32'hA1A1_A1A1;
        for (int cyc = 0; cyc < 60 && written < 8; cyc++) begin
            Ld_Valid = (issued < 8);
            Ld_Rd    = 5'(16 + issued);
            Ld_Data  = 32'h100 + 32'(issued);
            #1;
            accept = Ld_Valid && Ld_Ready;
            if (Ld_Valid && !Ld_Ready) saw_full = 1'b1;
            tick();
            if (accept) issued++;
            checks++; if (Wr_En !== 1'b1) begin failures++; $display("FAIL bp_wr_en cyc=%0d got=%b exp=1", cyc, Wr_En); end
            if (Wr_En === 1'b1) begin
                if (Write_Addr_Port_1 === 5'd1) begin
                    alu_w++;
                end else begin
                    checks++;
                    if (Write_Addr_Port_1 !== 5'(16 + written) || Write_Data_Port_1 !== 32'h100 + 32'(written)) begin
                        failures++;
                        $display("FAIL bp_order idx=%0d got=%0d/%h exp=%0d/%h", written, Write_Addr_Port_1,
                                 Write_Data_Port_1, 16 + written, 32'h100 + 32'(written));
                    end
                    written++;
                end
            end
        end
        idle_inputs();
        checks++; if (written != 8) begin failures++; $display("FAIL bp_all_loads got=%0d exp=8", written); end
        checks++; if (!saw_full) begin failures++; $display("FAIL bp_ld_ready_low got=0 exp=1"); end
        checks++; if (alu_w != 9) begin failures++; $display("FAIL bp_alu_count got=%0d exp=9", alu_w); end
    endtask

    task automatic test_scoreboard();
        Issue_Valid = 1'b1; Issue_Rd = 5'd0;
        tick();
        checks++; if (Busy_Vec !== 32'h0) begin failures++; $display("FAIL sb_x0 got=%h exp=0", Busy_Vec); end
        Issue_Rd = 5'd3;
        tick();
        checks++; if (Busy_Vec !== 32'h8) begin failures++; $display("FAIL sb_set got=%h exp=8", Busy_Vec); end
        Alu_Valid = 1'b1; Alu_Rd = 5'd3; Alu_Data = 32'h3333_0003;
        tick();
        Issue_Valid = 1'b0;
        checks++; if (Busy_Vec !== 32'h8) begin failures++; $display("FAIL sb_set_wins got=%h exp=8", Busy_Vec); end
        checks++; if (Wr_En !== 1'b1 || Write_Addr_Port_1 !== 5'd3) begin
            failures++; $display("FAIL sb_write got=%b/%0d exp=1/3", Wr_En, Write_Addr_Port_1);
        end
        Alu_Data = 32'h0000_3333;
        tick();
        Alu_Valid = 1'b0;
        checks++; if (Busy_Vec !== 32'h0) begin failures++; $display("FAIL sb_clear got=%h exp=0", Busy_Vec); end
    endtask

    task automatic test_x0_discard();
        Alu_Valid = 1'b1; Alu_Rd = 5'd0; Alu_Data = 32'hFFFF_FFFF;
        #1;
        checks++; if (Alu_Ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", Alu_Ready); end
        tick();
        Alu_Valid = 1'b0;
        checks++; if (Wr_En !== 1'b0) begin failures++; $display("FAIL x0_wr_en got=%b exp=0", Wr_En); end
        checks++; if (Write_Addr_Port_1 !== 5'd3 || Write_Data_Port_1 !== 32'h0000_3333) begin
            failures++; $display("FAIL x0_hold got=%0d/%h exp=3/00003333", Write_Addr_Port_1, Write_Data_Port_1);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        Alu_Valid = 1'b1; Alu_Rd = 5'd1; Alu_Data = 32'h5555;
        for (int i = 0; i < 4; i++) begin
            Ld_Valid    = 1'b1;
            Ld_Rd       = 5'(20 + i);
            Ld_Data     = 32'h200 + 32'(i);
            Issue_Valid = (i < 3);
            Issue_Rd    = 5'(7 + i);
            tick();
        end
        idle_inputs();
        checks++; if (Busy_Vec !== 32'h0000_0380) begin failures++; $display("FAIL mid_busy_pre got=%h exp=00000380", Busy_Vec); end
        checks++; if (Wr_En !== 1'b1) begin failures++; $display("FAIL mid_wr_pre got=%b exp=1", Wr_En); end
        #2;
        Rst_Core  = 1'b1;
        Alu_Valid = 1'b1;
        #1;
        checks++; if (Ld_Ready !== 1'b1) begin failures++; $display("FAIL mid_ld_ready got=%b exp=1", Ld_Ready); end
        checks++; if (Busy_Vec !== 32'h0) begin failures++; $display("FAIL mid_busy got=%h exp=0", Busy_Vec); end
        checks++; if (Wr_En !== 1'b0) begin failures++; $display("FAIL mid_wr_en got=%b exp=0", Wr_En); end
        checks++; if (Alu_Ready !== 1'b0) begin failures++; $display("FAIL mid_alu_ready got=%b exp=0", Alu_Ready); end
        Alu_Valid = 1'b0;
        tick();
        Rst_Core = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (Wr_En !== 1'b0) begin failures++; $display("FAIL mid_no_stale cyc=%0d got=%b/%0d exp=0", i, Wr_En, Write_Addr_Port_1); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_contention();
        test_backpressure();
        test_scoreboard();
        test_x0_discard();
        test_reset_midstream();
        tick();
        checks++; if (mon_fail != 0) begin failures++; $display("FAIL occupancy_monitor got=%0d exp=0", mon_fail); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
